// File: rtl/piso_reader_if.sv
// Load and serial handshake bundle for piso_reader.
// The master modport is the block side; slave is the storage/consumer side.
interface piso_reader_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_n;
  logic             sout_valid;
  logic             sout_last;
  logic             sout_ready;

  modport master (
    input  data_in,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_n,
    output sout_valid,
    output sout_last,
    input  sout_ready
  );

  modport slave (
    output data_in,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_n,
    input  sout_valid,
    input  sout_last,
    output sout_ready
  );
endinterface

// File: rtl/piso_reader.sv
// Parallel-in serial-out reader: loads one word on a valid/ready handshake and
// shifts it out MSB first with dual-rail registered serial outputs.
module piso_reader #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input logic          clk,
  input logic          reset,
  piso_reader_if.master bus_io
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             load_ready_q, sout_q, sout_n_q, sout_valid_q, sout_last_q;
  logic             shift_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.load_valid) begin
          shreg_d = bus_io.data_in;
          cnt_d   = CW'(WIDTH - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus_io.sout_ready) begin
          if (cnt_q == '0) begin
            shreg_d = '0;
            state_d = StIdle;
          end else begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state so they never see input glitches.
  assign shift_d = (state_d == StShift);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b1;
      sout_q       <= 1'b0;
      sout_n_q     <= 1'b1;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      load_ready_q <= !shift_d;
      sout_q       <= shift_d & shreg_d[WIDTH-1];
      sout_n_q     <= !(shift_d & shreg_d[WIDTH-1]);
      sout_valid_q <= shift_d;
      sout_last_q  <= shift_d && (cnt_d == '0);
    end
  end

  assign bus_io.load_ready = load_ready_q;
  assign bus_io.sout       = sout_q;
  assign bus_io.sout_n     = sout_n_q;
  assign bus_io.sout_valid = sout_valid_q;
  assign bus_io.sout_last  = sout_last_q;

endmodule

// File: tb/tb_piso_reader.sv
// Directed bench for piso_reader: WIDTH=8 and WIDTH=1 instances.
module tb_piso_reader;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  piso_reader_if #(.WIDTH(8)) if8 ();
  piso_reader_if #(.WIDTH(1)) if1 ();

  piso_reader #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .reset  (reset),
    .bus_io (if8)
  );

  piso_reader #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .bus_io (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, ".load_ready"}, {31'b0, if8.load_ready}, 32'd1);
    chk({tag, ".valid"},      {31'b0, if8.sout_valid}, 32'd0);
    chk({tag, ".sout"},       {31'b0, if8.sout},       32'd0);
    chk({tag, ".sout_n"},     {31'b0, if8.sout_n},     32'd1);
    chk({tag, ".last"},       {31'b0, if8.sout_last},  32'd0);
  endtask

  task automatic chk_bit8(input string tag, input logic b, input logic last);
    chk({tag, ".valid"},      {31'b0, if8.sout_valid}, 32'd1);
    chk({tag, ".load_ready"}, {31'b0, if8.load_ready}, 32'd0);
    chk({tag, ".sout"},       {31'b0, if8.sout},       {31'b0, b});
    chk({tag, ".sout_n"},     {31'b0, if8.sout_n},     {31'b0, ~b});
    chk({tag, ".last"},       {31'b0, if8.sout_last},  {31'b0, last});
  endtask

  // Drains bits first_idx..0 of word with sout_ready high, then expects IDLE.
  task automatic drain8(input string tag, input logic [7:0] word, input int first_idx);
    if8.sout_ready = 1'b1;
    for (int i = first_idx; i >= 0; i--) begin
      chk_bit8($sformatf("%s.b%0d", tag, i), word[i], (i == 0));
      step();
    end
    chk_idle8({tag, ".end"});
  endtask

  task automatic load8(input logic [7:0] word);
    if8.data_in    = word;
    if8.load_valid = 1'b1;
    if8.sout_ready = 1'b1;
    step();
    if8.load_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset          = 1'b0;
    if8.data_in    = 8'hFF;
    if8.load_valid = 1'b1;
    if8.sout_ready = 1'b0;
    if1.data_in    = 1'b0;
    if1.load_valid = 1'b0;
    if1.sout_ready = 1'b0;

    // Reset held with a pending load: must stay idle
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle8($sformatf("rst%0d", i));
    end
    chk("rst.w1.ready", {31'b0, if1.load_ready}, 32'd1);
    chk("rst.w1.sout_n", {31'b0, if1.sout_n}, 32'd1);
    reset = 1'b1;
    step();
    if8.load_valid = 1'b0;
    drain8("postrst", 8'hFF, 7);

    // Basic word
    load8(8'hA5);
    drain8("a5", 8'hA5, 7);

    // Backpressure after the 2nd bit
    load8(8'h81);
    chk_bit8("bp.b7", 1'b1, 1'b0);
    step();
    chk_bit8("bp.b6", 1'b0, 1'b0);
    step();
    if8.sout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_bit8($sformatf("bp.stall%0d", i), 1'b0, 1'b0);
      step();
    end
    drain8("bp", 8'h81, 5);

    // Load attempt during SHIFT is ignored, then taken in IDLE
    load8(8'h0F);
    chk_bit8("ign.b7", 1'b0, 1'b0);
    step();
    if8.data_in    = 8'hF0;
    if8.load_valid = 1'b1;
    drain8("ign", 8'h0F, 6);
    step();
    if8.load_valid = 1'b0;
    drain8("f0", 8'hF0, 7);

    // Asynchronous reset mid-word
    load8(8'hC3);
    for (int i = 7; i >= 5; i--) begin
      chk_bit8($sformatf("c3.b%0d", i), 1'b1 & ((8'hC3 >> i) & 8'h01) != 0, 1'b0);
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    chk_idle8("midrst");
    if8.data_in    = 8'h3C;
    if8.load_valid = 1'b1;
    #2;
    reset = 1'b1;
    step();
    if8.load_valid = 1'b0;
    drain8("3c", 8'h3C, 7);

    // WIDTH=1: single-cycle SHIFT, two-cycle load period
    if1.data_in    = 1'b1;
    if1.load_valid = 1'b1;
    if1.sout_ready = 1'b1;
    step();
    chk("w1.a.valid", {31'b0, if1.sout_valid}, 32'd1);
    chk("w1.a.sout",  {31'b0, if1.sout},       32'd1);
    chk("w1.a.last",  {31'b0, if1.sout_last},  32'd1);
    chk("w1.a.ready", {31'b0, if1.load_ready}, 32'd0);
    if1.data_in = 1'b0;
    step();
    chk("w1.idle.ready", {31'b0, if1.load_ready}, 32'd1);
    chk("w1.idle.valid", {31'b0, if1.sout_valid}, 32'd0);
    step();
    chk("w1.b.valid",  {31'b0, if1.sout_valid}, 32'd1);
    chk("w1.b.sout",   {31'b0, if1.sout},       32'd0);
    chk("w1.b.sout_n", {31'b0, if1.sout_n},     32'd1);
    chk("w1.b.last",   {31'b0, if1.sout_last},  32'd1);
    if1.load_valid = 1'b0;
    step();
    chk("w1.end.ready", {31'b0, if1.load_ready}, 32'd1);
    chk("w1.end.valid", {31'b0, if1.sout_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_reader.md
Name: piso_reader

Overview:
- Read-side companion to the team's latch-based storage cells: accepts one parallel word from a storage element on a valid/ready load handshake and shifts it out serially, MSB first, on a valid/ready serial handshake.
- Drives dual-rail outputs: the true output `sout` and its complement `sout_n`. This matches the complementary-output style of the storage cells.
- Sits between a latch/register bank and any bit-serial consumer, such as a serial link or a bit-serial ALU.

Parameters:
- WIDTH, 8: word length in bits; legal range 1..32.
- CW, $clog2(WIDTH) (minimum 1): bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset low forces the reset state immediately; release is synchronous to clk.
- data_in  input  WIDTH  parallel word from storage; sampled only on a load handshake.
- load_valid  input  1  upstream asserts when data_in holds a word to read.
- load_ready  output  1  block can accept a word.
- sout  output  1  current serial bit.
- sout_n  output  1  complement of sout; always exactly ~sout, including during reset.
- sout_valid  output  1  sout/sout_n/sout_last carry a valid bit.
- sout_last  output  1  current bit is the final (LSB) bit of the word.
- sout_ready  input  1  downstream accepts the current bit this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, counter=0.
  - Outputs: load_ready=1, sout=0, sout_n=1, sout_valid=0, sout_last=0.
- State IDLE:
  - load_ready=1, sout_valid=0, sout=0, sout_n=1, sout_last=0.
  - Load handshake (load_valid=1 and load_ready=1 at a clk edge): shift register <= data_in, counter <= WIDTH-1, state <= SHIFT.
- State SHIFT:
  - load_ready=0; load_valid is ignored and data_in is not sampled.
  - sout_valid=1, sout=shreg[WIDTH-1], sout_n=~sout, sout_last=(counter==0).
- Bit transfer (sout_valid=1 and sout_ready=1 at a clk edge):
  - If counter==0: state <= IDLE, shift register <= 0.
  - Otherwise: shift register shifts left by one (0 into the LSB) and counter decrements by 1.
- Stall: sout_ready=0 holds shreg, the counter and all outputs unchanged for any number of cycles.
- Latency and throughput:
  - First bit is valid in the cycle after the load handshake.
  - With sout_ready held high, a word takes WIDTH cycles in SHIFT plus 1 cycle in IDLE, so the load-to-load period is WIDTH+1 cycles.
  - No back-to-back overlap; load_ready stays low until IDLE is re-entered.
- WIDTH=1: SHIFT lasts exactly one transfer and sout_last=1 throughout.
- Reset mid-word: the remaining bits are discarded and the outputs take reset values asynchronously. After reset release the block sits in IDLE and is ready on the next edge.
- Output timing: all outputs are decoded from registered state only, with no combinational path from inputs to outputs. load_ready is a pure function of the state.
- Data ordering: bit i of data_in appears on the (WIDTH-i)th transfer, so bit WIDTH-1 comes first and bit 0 comes last.

Test Plan:
- Reset: hold reset=0 with load_valid=1 and data_in=8'hFF, toggling clk -> load_ready=1, sout_valid=0, sout=0, sout_n=1 throughout. After release, the first edge with load_valid=1 loads the word.
- Basic word: load 8'hA5, sout_ready=1 -> sout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, sout_n the inverse each cycle, sout_last=1 only on the 8th, load_ready=1 on the 9th.
- Backpressure: load 8'h81, then drop sout_ready for 3 cycles after the 2nd bit -> sout=0 and sout_valid=1 held for 3 cycles, counter and data unchanged, remaining sequence 0,0,0,0,0,1 completes with correct sout_last.
- Load ignored in SHIFT: after loading 8'h0F, pulse load_valid with data_in=8'hF0 mid-word -> output is still 0,0,0,0,1,1,1,1, and 8'hF0 loads only when back in IDLE.
- Reset mid-word: assert reset=0 asynchronously (between clk edges) after the 3rd bit of 8'hC3 -> sout_valid drops and sout=0, sout_n=1 immediately. After release, loading 8'h3C yields 0,0,1,1,1,1,0,0.
- WIDTH=1 instance: load 1'b1 -> a single cycle with sout=1, sout_last=1, sout_valid=1, then IDLE. Consecutive loads show the 2-cycle period.
